// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
// Request/response bus between the core's load/store stage and the data-memory
// access controller.
//   req_valid   : request present (core -> controller)
//   req_we      : 1 = store, 0 = load
//   req_funct3  : RISC-V funct3 of the load/store
//   req_addr    : byte address
//   req_wdata   : store data, low-aligned
//   req_ready   : request accepted this cycle when req_valid=1 (controller -> core)
//   resp_valid  : one-cycle completion pulse
//   resp_err    : qualifies resp_valid, request was misaligned/illegal
//   resp_rdata  : extended load data
// Modports: master = core side, slave = controller side.
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_err, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_err, resp_rdata
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Accepts one RISC-V load/store at a time, decodes funct3 into byte enables and
// replicated write data, holds the single-port SRAM selected until mem_ready,
// then returns sign/zero-extended load data with a one-cycle response pulse.
// Misaligned or illegal requests get an error response without touching memory.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   core       : request/response bus (slave modport)
//   mem_csn    : SRAM select, active-low
//   mem_wen    : 1 = read, 0 = write
//   mem_addr   : SRAM word address (req_addr[AWIDTH+1:2], upper bits alias)
//   mem_be     : byte enables
//   mem_di     : SRAM write data
//   mem_dout   : SRAM read data
//   mem_ready  : SRAM access complete (only looked at in ACCESS)
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
   parameter int AWIDTH = 12
) (
   input  logic                clk,
   input  logic                rst,
   dmem_access_ctrl_if.slave   core,
   output logic                mem_csn,
   output logic                mem_wen,
   output logic [AWIDTH-1:0]   mem_addr,
   output logic [3:0]          mem_be,
   output logic [31:0]         mem_di,
   input  logic [31:0]         mem_dout,
   input  logic                mem_ready
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

   state_t      state;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;

   // Address bits above the SRAM word range alias; collected here on purpose.
   logic [31:0] unused_addr;
   assign unused_addr = core.req_addr;

   function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
      logic bad;
      if (we) bad = f3[2] || (f3[1:0] == 2'b11);
      else    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      if ((f3[1:0] == 2'b01) && off[0])          bad = 1'b1;
      if ((f3[1:0] == 2'b10) && (off != 2'b00))  bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      unique case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_di(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] di;
      unique case (f3[1:0])
         2'b00:   di = {4{wd[7:0]}};
         2'b01:   di = {2{wd[15:0]}};
         default: di = wd;
      endcase
      return di;
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      unique case (off)
         2'b00:   b = w[7:0];
         2'b01:   b = w[15:8];
         2'b10:   b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      unique case (f3)
         3'b000:  r = 32'(b);          // LB, sign-extended
         3'b001:  r = 32'(h);          // LH, sign-extended
         3'b100:  r = {24'd0, b};      // LBU
         3'b101:  r = {16'd0, h};      // LHU
         default: r = w;               // LW
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         f3_q       <= 3'd0;
         off_q      <= 2'd0;
         mem_csn    <= 1'b1;
         mem_wen    <= 1'b1;
         mem_addr   <= '0;
         mem_be     <= 4'd0;
         mem_di     <= 32'd0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
      end else begin
         unique case (state)
            // IDLE: latch the request and decide between error and SRAM access
            IDLE: begin
               if (core.req_valid) begin
                  we_q  <= core.req_we;
                  f3_q  <= core.req_funct3;
                  off_q <= core.req_addr[1:0];
                  if (is_illegal(core.req_we, core.req_funct3, core.req_addr[1:0])) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                  end else begin
                     state    <= ACCESS;
                     mem_csn  <= 1'b0;
                     mem_wen  <= ~core.req_we;
                     mem_addr <= core.req_addr[AWIDTH+1:2];
                     mem_be   <= core.req_we ? store_be(core.req_funct3, core.req_addr[1:0]) : 4'd0;
                     if (core.req_we)
                        mem_di <= store_di(core.req_funct3, core.req_wdata);
                  end
               end
            end
            // ACCESS: SRAM selected with stable outputs until it reports ready
            ACCESS: begin
               if (mem_ready) begin
                  mem_csn <= 1'b1;
                  if (we_q) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                  end else begin
                     state <= CAPTURE;
                  end
               end
            end
            // CAPTURE: read data is valid on mem_dout this cycle
            CAPTURE: begin
               resp_rdata <= load_extract(f3_q, off_q, mem_dout);
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
            end
            // RESP: single-cycle response pulse
            RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign core.req_ready  = (state == IDLE) && !rst;
   assign core.resp_valid = resp_valid;
   assign core.resp_err   = resp_err;
   assign core.resp_rdata = resp_rdata;

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller between the core's load/store stage and the latency-modelled single-port data SRAM (CSN/ADDR/WEN/BE/DI/DOUT/READY interface). It accepts one RISC-V load/store request at a time and decodes funct3 into byte enables and replicated write data. It holds the SRAM selected until READY, then returns sign- or zero-extended load data with a single-cycle response pulse. Misaligned or illegal requests are rejected with an error response and no memory access.

## Interface
- AWIDTH, 12: SRAM word-address width; MEM_ADDR = REQ_ADDR[AWIDTH+1:2], upper address bits ignored (aliasing).
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  1  request present
- REQ_WE  in  1  1 = store, 0 = load
- REQ_FUNCT3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data, low-aligned
- REQ_READY  out  1  request accepted this cycle when REQ_VALID=1
- RESP_VALID  out  1  one-cycle completion pulse
- RESP_ERR  out  1  qualifies RESP_VALID: misaligned/illegal
- RESP_RDATA  out  32  extended load data
- MEM_CSN  out  1  SRAM select, active-low
- MEM_WEN  out  1  1 = read, 0 = write
- MEM_ADDR  out  AWIDTH  SRAM word address
- MEM_BE  out  4  byte enables
- MEM_DI  out  32  SRAM write data
- MEM_DOUT  in  32  SRAM read data
- MEM_READY  in  1  SRAM access complete

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: REQ_READY = 1, combinational and gated by ~RST. On REQ_VALID, latch WE/funct3/addr/wdata.
  - Illegal request -> RESP with RESP_ERR=1; MEM_CSN stays 1.
  - Otherwise -> ACCESS.
- Illegal: load funct3 in {011,110,111}; store funct3 > 010; half access with addr[0]=1; word access with addr[1:0]≠00.
- ACCESS: MEM_CSN=0; memory outputs are registered from the latch and stable for the whole state. The state exits at the edge where MEM_READY=1: store -> RESP, load -> CAPTURE.
- CAPTURE: MEM_CSN=1; MEM_DOUT is sampled at the end of this cycle, extracted and registered into RESP_RDATA; -> RESP.
- RESP: RESP_VALID=1 for exactly one cycle; -> IDLE. REQ_READY=0 in every state except IDLE.
- Store encoding:
  - SB: BE = 0001 << addr[1:0], DI = {4{wdata[7:0]}}.
  - SH: BE = addr[1] ? 1100 : 0011, DI = {2{wdata[15:0]}}.
  - SW: BE = 1111, DI = wdata.
- Load encoding: MEM_WEN=1, BE=0000.
  - LB/LBU: lane addr[1:0], sign/zero-extend.
  - LH/LHU: lane addr[1], sign/zero-extend.
  - LW: whole word.
- RESP_RDATA is written only in CAPTURE (loads) and cleared on error responses. It holds its value otherwise; stores leave it unchanged.
- MEM_READY is ignored outside ACCESS.

## Timing
- Reset values: state IDLE, MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_DI=0, MEM_ADDR=0, RESP_VALID=0, RESP_ERR=0, RESP_RDATA=0; REQ_READY=0 while RST=1.
- Acceptance edge T is the end of the IDLE cycle with REQ_VALID=1. For SRAM latency L (1..7), ACCESS occupies cycles T+1..T+L, and MEM_READY rises in the L-th ACCESS cycle.
- Store: RESP_VALID in cycle T+L+1.
- Load: CAPTURE in T+L+1; RESP_VALID with data in T+L+2.
- Error: RESP_VALID, RESP_ERR=1 in T+1.
- Minimum spacing: the next request can be accepted in the cycle after RESP. Back-to-back throughput: a store every L+2 cycles, a load every L+3.
- MEM_CSN deasserts in the cycle after READY. No SRAM cycle re-arms, so the SRAM latency counter restarts from 0 for the next access.
- Store data may be written on several edges during ACCESS. This is allowed; the data is identical each time.
- RST during ACCESS/CAPTURE/RESP: next cycle in IDLE with reset outputs, no response issued. A store that has already seen one ACCESS edge may have been written.
- REQ_* are sampled only at the acceptance edge; later changes are ignored.

## Test plan
- Reset, then hold REQ_VALID=0 -> MEM_CSN=1, RESP_VALID=0, RESP_RDATA=0; REQ_READY=1 from the first cycle after RST drops.
- L=3, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ACCESS 3 cycles with MEM_ADDR=4, BE=1111; store RESP at T+4; load RESP at T+5 with RDATA=0xDEADBEEF.
- L=1, SB 0x13 data 0x80 then LB 0x13 and LBU 0x13 -> BE=1000, DI=0x80808080; RDATA=0xFFFFFF80, then 0x00000080.
- L=2, SH 0x22 data 0x1234ABCD then LH 0x22 / LHU 0x20 (word prefilled 0) -> BE=1100; RDATA=0xFFFFABCD, then 0x00000000.
- LW 0x11, LH 0x01, funct3=011 -> each gives RESP_ERR=1 at T+1, MEM_CSN never low, RESP_RDATA=0.
- L=4, assert RST for one cycle in the 2nd ACCESS cycle of a load -> no RESP_VALID, MEM_CSN=1 next cycle; a following LW completes at T+6 with correct data.
